pwl_coef_table: RTL and testbench
=================================

// Module: pwl_coef_table
// PURPOSE
//  Parametrised, runtime-loadable piecewise-linear coefficient table for the activation datapath.
//  Holds NUM_FUNC banks (e.g. exp2, silu/softplus) of 2**SEG_W entries. Each entry is {y0, slope} in FP16.
//  Serves LANES parallel segment lookups per cycle through a 2-stage pipeline.
//  An init FSM clears the table after reset or on clr_i. Coefficients are written through a write port.
// PARAMETERS
//  DW        16  coefficient width (FP16 bit pattern)
//  SEG_W     3   segment index width; entries per bank = 2**SEG_W (SEG_W >= 3)
//  NUM_FUNC  2   number of function banks (>= 1); FW = (NUM_FUNC>1) ? $clog2(NUM_FUNC) : 1
//  LANES     1   parallel lookup lanes sharing func_i/valid_i
// PORTS
//  clk          in   1            clock, all logic on posedge
//  rstn         in   1            asynchronous active-low reset
//  clr_i        in   1            synchronous re-initialise request
//  valid_i      in   1            lookup request valid
//  func_i       in   FW           bank select for the lookup
//  seg_i        in   LANES*SEG_W  segment index per lane (lane 0 in LSBs)
//  y0_o         out  LANES*DW     segment base value per lane
//  slope_o      out  LANES*DW     segment slope per lane
//  valid_o      out  1            lookup result valid
//  ready_o      out  1            table is in RUN; lookups and writes are accepted
//  wr_en_i      in   1            coefficient write strobe
//  wr_func_i    in   FW           write bank
//  wr_seg_i     in   SEG_W        write entry
//  wr_y0_i      in   DW           write y0 value
//  wr_slope_i   in   DW           write slope value
// BEHAVIOUR
//  - Reset (rstn=0): state=INIT, init counter=0, ready_o=0.
//    y0_o, slope_o and valid_o are 0. All pipeline valids are 0.
//  - FSM INIT: each cycle writes entry cnt (bank=cnt>>SEG_W, seg=cnt[SEG_W-1:0]) with its init value, then cnt++.
//    After entry NUM_FUNC*2**SEG_W-1 is written -> RUN. ready_o=1 from the following cycle.
//    Init therefore takes exactly NUM_FUNC*2**SEG_W cycles.
//  - FSM RUN: clr_i=1 -> INIT with cnt=0 on the next edge. clr_i is ignored while in INIT.
//  - While ready_o=0: valid_i and wr_en_i are ignored, and stage-1 valid is forced to 0.
//  - Entering INIT flushes both pipeline valids to 0 on the same edge. No stale result is emitted.
//  - Lookup latency is 2 cycles.
//    - Stage 1 registers {valid_i & ready_o, func_i, seg_i}.
//    - Stage 2 reads the table and registers y0_o/slope_o/valid_o.
//    - Back-to-back lookups every cycle are supported; there is no backpressure.
//  - When valid_o=0, y0_o/slope_o hold their last values. Only valid_o is qualified.
//  - func_i >= NUM_FUNC: the lane outputs are 0 and valid_o still asserts (defined, not an error).
//  - Write: if wr_en_i & ready_o, the entry {wr_func_i, wr_seg_i} is updated at the clock edge.
//    wr_func_i >= NUM_FUNC drops the write.
//  - Read/write collision: a stage-2 read of the entry written in the same cycle returns the OLD value.
//    The new value is visible to reads in stage 2 from the next cycle on.
//  - Init value without the macro: y0=0, slope=0 for every entry.
//  - Table storage is registers. The LANES read muxes are independent. All lanes use the same func_i.
// CONFIGURATION
//  PWL_DEFAULT_EXP2_EN defined: the INIT FSM loads bank 0 with the 8-segment 2^x table.
//    Entry s uses default k = s[SEG_W-1 -: 3].
//    k=0..7 y0  = 3C00,3C5D,3CC2,3D30,3DA8,3E2B,3EBA,3F56
//    k=0..7 slope = 39CB,3A51,3AE3,3B83,3C19,3C77,3CDF,3D50
//    All other banks are zeroed.
//  PWL_DEFAULT_EXP2_EN undefined: every bank is zeroed. The ports and timing are identical in both builds.
// TESTING
//  1. Release rstn; count cycles until ready_o=1.
//     -> defaults: exactly 16 cycles. valid_o stays 0 throughout, even with valid_i held at 1.
//  2. Write bank1 seg5 = {4000,3800}. Lookup func=1 seg=5 two cycles later.
//     -> y0_o=4000, slope_o=3800, valid_o one cycle... 2 cycles after valid_i.
//  3. Write bank1 seg2 = {4400,4200} in the same cycle that a stage-2 read of bank1 seg2 occurs.
//     -> that read returns the old value 0000. The next lookup returns 4400.
//  4. Issue a lookup every cycle for 8 cycles, seg 0..7, bank 0, with the macro defined.
//     -> 8 consecutive valid_o pulses. y0 sequence runs 3C00 through 3F56 in order.
//  5. Assert clr_i while 2 lookups are in flight.
//     -> no valid_o pulses. ready_o=0 for 16 cycles. Earlier writes read back as 0 after re-init.
//  6. Build with LANES=2, SEG_W=4; lookup seg_i={4'd15,4'd0}, bank 0, macro defined.
//     -> lane0 = {3C00,39CB}, lane1 = {3F56,3D50}.

Source files
------------

// File: rtl/pwl_coef_table.sv
// Runtime-loadable piecewise-linear {y0, slope} coefficient table with a 2-stage lookup pipeline.
// Optional macro PWL_DEFAULT_EXP2_EN: init loads bank 0 with the 8-segment 2^x table instead of zeros.
module pwl_coef_table #(
  parameter int unsigned DW       = 16,
  parameter int unsigned SEG_W    = 3,
  parameter int unsigned NUM_FUNC = 2,
  parameter int unsigned LANES    = 1,
  localparam int unsigned FW      = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr_i,
  input  logic                   valid_i,
  input  logic [FW-1:0]          func_i,
  input  logic [LANES*SEG_W-1:0] seg_i,
  output logic [LANES*DW-1:0]    y0_o,
  output logic [LANES*DW-1:0]    slope_o,
  output logic                   valid_o,
  output logic                   ready_o,
  input  logic                   wr_en_i,
  input  logic [FW-1:0]          wr_func_i,
  input  logic [SEG_W-1:0]       wr_seg_i,
  input  logic [DW-1:0]          wr_y0_i,
  input  logic [DW-1:0]          wr_slope_i
);

  localparam int unsigned ENT     = 2**SEG_W;
  localparam int unsigned ENTRIES = NUM_FUNC * ENT;
  localparam int unsigned CNT_W   = $clog2(ENTRIES);
  localparam int unsigned FN      = 2**FW;
  // One bit per encodable bank select; set only for banks that exist.
  localparam logic [FN-1:0] FUNC_OK = FN'((64'd1 << NUM_FUNC) - 64'd1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic                   go_init;

  logic [DW-1:0]          y0_tbl_q    [NUM_FUNC][ENT];
  logic [DW-1:0]          y0_tbl_d    [NUM_FUNC][ENT];
  logic [DW-1:0]          slope_tbl_q [NUM_FUNC][ENT];
  logic [DW-1:0]          slope_tbl_d [NUM_FUNC][ENT];

  logic                   s1_valid_q, s1_valid_d;
  logic [FW-1:0]          s1_func_q, s1_func_d;
  logic [LANES*SEG_W-1:0] s1_seg_q, s1_seg_d;
  logic                   valid_q, valid_d;
  logic [LANES*DW-1:0]    y0_q, y0_d, slope_q, slope_d;

  logic [FW-1:0]          init_bank;
  logic [SEG_W-1:0]       init_seg;
  logic [DW-1:0]          init_y0, init_slope;
  logic [SEG_W-1:0]       lane_seg;

  assign init_bank = FW'(cnt_q >> SEG_W);
  assign init_seg  = cnt_q[SEG_W-1:0];

  // Init/run sequencing; go_init marks the edge that flushes the pipeline.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    go_init = 1'b0;
    case (state_q)
      S_INIT: begin
        if (cnt_q == CNT_W'(ENTRIES - 1)) begin
          state_d = S_RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (clr_i) begin
          state_d = S_INIT;
          cnt_d   = '0;
          ready_d = 1'b0;
          go_init = 1'b1;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Table update: init sweep has priority; runtime writes only to existing banks.
  always_comb begin
    y0_tbl_d    = y0_tbl_q;
    slope_tbl_d = slope_tbl_q;
    init_y0     = '0;
    init_slope  = '0;
`ifdef PWL_DEFAULT_EXP2_EN
    if (init_bank == FW'(0)) begin
      case (init_seg[SEG_W-1 -: 3])
        3'd0:    begin init_y0 = DW'(16'h3C00); init_slope = DW'(16'h39CB); end
        3'd1:    begin init_y0 = DW'(16'h3C5D); init_slope = DW'(16'h3A51); end
        3'd2:    begin init_y0 = DW'(16'h3CC2); init_slope = DW'(16'h3AE3); end
        3'd3:    begin init_y0 = DW'(16'h3D30); init_slope = DW'(16'h3B83); end
        3'd4:    begin init_y0 = DW'(16'h3DA8); init_slope = DW'(16'h3C19); end
        3'd5:    begin init_y0 = DW'(16'h3E2B); init_slope = DW'(16'h3C77); end
        3'd6:    begin init_y0 = DW'(16'h3EBA); init_slope = DW'(16'h3CDF); end
        default: begin init_y0 = DW'(16'h3F56); init_slope = DW'(16'h3D50); end
      endcase
    end
`endif
    if (state_q == S_INIT) begin
      y0_tbl_d[init_bank][init_seg]    = init_y0;
      slope_tbl_d[init_bank][init_seg] = init_slope;
    end else if (wr_en_i && ready_q && FUNC_OK[wr_func_i]) begin
      y0_tbl_d[wr_func_i][wr_seg_i]    = wr_y0_i;
      slope_tbl_d[wr_func_i][wr_seg_i] = wr_slope_i;
    end
  end

  // Lookup pipeline: stage 1 captures the request, stage 2 reads the pre-write table.
  always_comb begin
    s1_valid_d = valid_i & ready_q & ~go_init;
    s1_func_d  = func_i;
    s1_seg_d   = seg_i;
    valid_d    = s1_valid_q & ~go_init;
    y0_d       = y0_q;
    slope_d    = slope_q;
    lane_seg   = '0;
    if (valid_d) begin
      for (int l = 0; l < int'(LANES); l++) begin
        lane_seg = s1_seg_q[l*SEG_W +: SEG_W];
        if (FUNC_OK[s1_func_q]) begin
          y0_d[l*DW +: DW]    = y0_tbl_q[s1_func_q][lane_seg];
          slope_d[l*DW +: DW] = slope_tbl_q[s1_func_q][lane_seg];
        end else begin
          y0_d[l*DW +: DW]    = '0;
          slope_d[l*DW +: DW] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_func_q  <= '0;
      s1_seg_q   <= '0;
      valid_q    <= 1'b0;
      y0_q       <= '0;
      slope_q    <= '0;
      for (int f = 0; f < int'(NUM_FUNC); f++) begin
        for (int s = 0; s < int'(ENT); s++) begin
          y0_tbl_q[f][s]    <= '0;
          slope_tbl_q[f][s] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      s1_valid_q  <= s1_valid_d;
      s1_func_q   <= s1_func_d;
      s1_seg_q    <= s1_seg_d;
      valid_q     <= valid_d;
      y0_q        <= y0_d;
      slope_q     <= slope_d;
      y0_tbl_q    <= y0_tbl_d;
      slope_tbl_q <= slope_tbl_d;
    end
  end

  assign y0_o    = y0_q;
  assign slope_o = slope_q;
  assign valid_o = valid_q;
  assign ready_o = ready_q;

endmodule

// File: tb/tb_pwl_coef_table.sv
// Directed bench for pwl_coef_table: default build plus a LANES=2/SEG_W=4 instance.
module tb_pwl_coef_table;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        clr_i, valid_i, func_i, wr_en_i, wr_func_i;
  logic [2:0]  seg_i, wr_seg_i;
  logic [15:0] y0_o, slope_o, wr_y0_i, wr_slope_i;
  logic        valid_o, ready_o;

  logic        clr2, v2, f2, wr_en2, wr_func2;
  logic [7:0]  seg2;
  logic [3:0]  wr_seg2;
  logic [15:0] wr_y02, wr_sl2;
  logic [31:0] y02, sl2;
  logic        vo2, rdy2;

  pwl_coef_table u_dut (
    .clk(clk), .rstn(rstn), .clr_i(clr_i), .valid_i(valid_i), .func_i(func_i),
    .seg_i(seg_i), .y0_o(y0_o), .slope_o(slope_o), .valid_o(valid_o), .ready_o(ready_o),
    .wr_en_i(wr_en_i), .wr_func_i(wr_func_i), .wr_seg_i(wr_seg_i),
    .wr_y0_i(wr_y0_i), .wr_slope_i(wr_slope_i)
  );

  pwl_coef_table #(.SEG_W(4), .LANES(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .clr_i(clr2), .valid_i(v2), .func_i(f2),
    .seg_i(seg2), .y0_o(y02), .slope_o(sl2), .valid_o(vo2), .ready_o(rdy2),
    .wr_en_i(wr_en2), .wr_func_i(wr_func2), .wr_seg_i(wr_seg2),
    .wr_y0_i(wr_y02), .wr_slope_i(wr_sl2)
  );

`ifdef PWL_DEFAULT_EXP2_EN
  logic [15:0] exp_y0 [8] = '{16'h3C00, 16'h3C5D, 16'h3CC2, 16'h3D30,
                              16'h3DA8, 16'h3E2B, 16'h3EBA, 16'h3F56};
  logic [15:0] exp_sl [8] = '{16'h39CB, 16'h3A51, 16'h3AE3, 16'h3B83,
                              16'h3C19, 16'h3C77, 16'h3CDF, 16'h3D50};
`else
  logic [15:0] exp_y0 [8] = '{default: 16'h0000};
  logic [15:0] exp_sl [8] = '{default: 16'h0000};
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Single lookup issued at a negedge; result checked 2 cycles later, then held.
  task automatic lookup(input string tag, input logic f, input logic [2:0] s,
                        input logic [15:0] ey, input logic [15:0] es);
    valid_i = 1'b1; func_i = f; seg_i = s;
    @(negedge clk);
    valid_i = 1'b0;
    check({tag, "_lat1"}, 64'(valid_o), 64'd0);
    @(negedge clk);
    check({tag, "_v"}, 64'(valid_o), 64'd1);
    check({tag, "_y0"}, 64'(y0_o), 64'(ey));
    check({tag, "_sl"}, 64'(slope_o), 64'(es));
    @(negedge clk);
    check({tag, "_pulse"}, 64'(valid_o), 64'd0);
    check({tag, "_hold"}, 64'(y0_o), 64'(ey));
  endtask

  task automatic write(input logic f, input logic [2:0] s, input logic [15:0] y, input logic [15:0] sl);
    wr_en_i = 1'b1; wr_func_i = f; wr_seg_i = s; wr_y0_i = y; wr_slope_i = sl;
    @(negedge clk);
    wr_en_i = 1'b0;
  endtask

  int   cyc;
  logic bad;

  initial begin
    rstn = 1'b0; clr_i = 1'b0; valid_i = 1'b1; func_i = 1'b0; seg_i = '0;
    wr_en_i = 1'b0; wr_func_i = 1'b0; wr_seg_i = '0; wr_y0_i = '0; wr_slope_i = '0;
    clr2 = 1'b0; v2 = 1'b1; f2 = 1'b0; seg2 = '0;
    wr_en2 = 1'b0; wr_func2 = 1'b0; wr_seg2 = '0; wr_y02 = '0; wr_sl2 = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_y0", 64'(y0_o), 64'd0);
    check("rst_slope", 64'(slope_o), 64'd0);
    check("rst_ready2", 64'(rdy2), 64'd0);

    // Init length with valid_i held high
    rstn = 1'b1;
    cyc = 0; bad = 1'b0;
    while (!ready_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (valid_o) bad = 1'b1;
    end
    valid_i = 1'b0; v2 = 1'b0;
    check("init_cycles", 64'(cyc), 64'd16);
    check("init_no_valid", 64'(bad), 64'd0);
    @(negedge clk);
    check("init_no_valid_after", 64'(valid_o), 64'd0);

    // Write then read back
    write(1'b1, 3'd5, 16'h4000, 16'h3800);
    lookup("wr_rd", 1'b1, 3'd5, 16'h4000, 16'h3800);

    // Collision: write lands on the same edge as the stage-2 read
    valid_i = 1'b1; func_i = 1'b1; seg_i = 3'd2;
    @(negedge clk);
    valid_i = 1'b0;
    wr_en_i = 1'b1; wr_func_i = 1'b1; wr_seg_i = 3'd2; wr_y0_i = 16'h4400; wr_slope_i = 16'h4200;
    @(negedge clk);
    wr_en_i = 1'b0;
    check("coll_v", 64'(valid_o), 64'd1);
    check("coll_old_y0", 64'(y0_o), 64'h0000);
    check("coll_old_sl", 64'(slope_o), 64'h0000);
    lookup("coll_new", 1'b1, 3'd2, 16'h4400, 16'h4200);

    // Back-to-back burst over bank 0
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        check("burst_v", 64'(valid_o), 64'd1);
        check("burst_y0", 64'(y0_o), 64'(exp_y0[i-2]));
        check("burst_sl", 64'(slope_o), 64'(exp_sl[i-2]));
      end
      if (i < 8) begin valid_i = 1'b1; func_i = 1'b0; seg_i = 3'(i); end
      else valid_i = 1'b0;
      @(negedge clk);
    end
    check("burst_end", 64'(valid_o), 64'd0);

    // clr_i with two lookups in flight
    valid_i = 1'b1; func_i = 1'b0; seg_i = 3'd0;
    @(negedge clk);
    seg_i = 3'd1; clr_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; clr_i = 1'b0;
    cyc = 0; bad = 1'b0;
    while (!ready_o && cyc < 100) begin
      if (valid_o) bad = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check("clr_ready_low", 64'(cyc), 64'd16);
    check("clr_no_valid", 64'(bad), 64'd0);
    lookup("clr_wipe5", 1'b1, 3'd5, 16'h0000, 16'h0000);
    lookup("clr_wipe2", 1'b1, 3'd2, 16'h0000, 16'h0000);
    lookup("clr_bank0", 1'b0, 3'd3, exp_y0[3], exp_sl[3]);

    // Two-lane instance, segments 0 and 15 of bank 0
    check("l2_ready", 64'(rdy2), 64'd1);
    v2 = 1'b1; f2 = 1'b0; seg2 = {4'd15, 4'd0};
    @(negedge clk);
    v2 = 1'b0;
    @(negedge clk);
    check("l2_v", 64'(vo2), 64'd1);
    check("l2_y0", 64'(y02), 64'({exp_y0[7], exp_y0[0]}));
    check("l2_sl", 64'(sl2), 64'({exp_sl[7], exp_sl[0]}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
